// File: rtl/ram_16x8_arbiter.sv
// Clears a 16x8 single-port RAM after reset, then round-robin shares it between two requesters, one access per clock.
// Read data returns 2 cycles after acceptance on a one-cycle pulse; requests wait on ready and responses cannot be stalled.
module ram_16x8_arbiter #(
  parameter logic [7:0] INIT_VAL = 8'h00,
  parameter bit         INIT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       init_done,
  output logic       ram_wr_en,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       init_done_q, init_done_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s1_id_q, s1_id_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;

  logic       run;
  logic       init_act;
  logic       grant;
  logic       xfer;
  logic       sel_we;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata;

  // Gating with rst_n forces the RAM port and readies quiet while reset is held.
  assign run      = rst_n && (state_q == ST_RUN);
  assign init_act = rst_n && (state_q == ST_INIT);

  // On a tie the port that did not win last time is chosen.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
  assign req0_ready = run && req0_valid && !grant;
  assign req1_ready = run && req1_valid && grant;
  assign xfer       = req0_ready || req1_ready;

  assign sel_we    = grant ? req1_we    : req0_we;
  assign sel_addr  = grant ? req1_addr  : req0_addr;
  assign sel_wdata = grant ? req1_wdata : req0_wdata;

  always_comb begin
    ram_wr_en = 1'b0;
    ram_addr  = addr_q;
    ram_din   = din_q;
    if (init_act) begin
      ram_wr_en = 1'b1;
      ram_addr  = cnt_q;
      ram_din   = INIT_VAL;
    end else if (xfer) begin
      ram_wr_en = sel_we;
      ram_addr  = sel_addr;
      if (sel_we) begin
        ram_din = sel_wdata;
      end
    end
  end

  assign addr_d = ram_addr;
  assign din_d  = ram_din;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN:  ;
      default: ;
    endcase
  end

  assign last_grant_d = xfer ? grant : last_grant_q;

  // Stage 1 lines up with ram_dout; stage 2 presents the captured word.
  assign s1_vld_d  = xfer && !sel_we;
  assign s1_id_d   = grant;
  assign rsp_vld_d = s1_vld_q;
  assign rsp_id_d  = s1_id_q;
  assign rdata0_d  = (s1_vld_q && !s1_id_q) ? ram_dout : rdata0_q;
  assign rdata1_d  = (s1_vld_q &&  s1_id_q) ? ram_dout : rdata1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      init_done_q  <= !INIT_EN;
      addr_q       <= 4'd0;
      din_q        <= 8'h00;
      s1_vld_q     <= 1'b0;
      s1_id_q      <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      init_done_q  <= init_done_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      s1_vld_q     <= s1_vld_d;
      s1_id_q      <= s1_id_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign rsp0_valid = rsp_vld_q && !rsp_id_q;
  assign rsp1_valid = rsp_vld_q &&  rsp_id_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_ram_16x8_arbiter.sv
// Bench for ram_16x8_arbiter: directed scenarios plus randomized two-port traffic against a behavioural memory/arbiter model.
module tb_ram_16x8_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       init_done, ram_wr_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic       rst_n_b;
  logic       b_req0_valid, b_req0_ready, b_req0_we;
  logic [3:0] b_req0_addr;
  logic [7:0] b_req0_wdata;
  logic       b_req1_valid, b_req1_ready, b_req1_we;
  logic [3:0] b_req1_addr;
  logic [7:0] b_req1_wdata;
  logic       b_rsp0_valid, b_rsp1_valid;
  logic [7:0] b_rsp0_rdata, b_rsp1_rdata;
  logic       b_init_done, b_ram_wr_en;
  logic [3:0] b_ram_addr;
  logic [7:0] b_ram_din, b_ram_dout;

  ram_16x8_arbiter #(.INIT_VAL(8'h5A), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .init_done(init_done), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram_16x8_arbiter #(.INIT_VAL(8'h00), .INIT_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(b_req0_we),
    .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_we(b_req1_we),
    .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
    .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .init_done(b_init_done), .ram_wr_en(b_ram_wr_en), .ram_addr(b_ram_addr),
    .ram_din(b_ram_din), .ram_dout(b_ram_dout)
  );

  // Single-port RAM with registered read, sharing the clock.
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int errs = 0;
  int checks = 0;

  // Model state: last winning port, memory image, expected responses, held read data.
  typedef struct { int due; bit port; logic [7:0] data; } rsp_t;
  rsp_t       rq [$];
  logic       m_last;
  logic [7:0] ref_mem [16];
  logic [7:0] exp_rd0, exp_rd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 4'h0; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 4'h0; req1_wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rst_n_b = 1'b0;
    idle_reqs();
    req0_valid = 1'b1; req0_addr = 4'h7;
    req1_valid = 1'b1; req1_addr = 4'h8;
    b_req0_valid = 1'b1; b_req0_we = 1'b0; b_req0_addr = 4'h3; b_req0_wdata = 8'h00;
    b_req1_valid = 1'b0; b_req1_we = 1'b0; b_req1_addr = 4'h0; b_req1_wdata = 8'h00;
    b_ram_dout = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, ram_wr_en} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, ram_wr_en});
    end
    checks++;
    if ({ram_addr, ram_din, rsp0_rdata, rsp1_rdata} !== 28'h0) begin
      errs++;
      $display("FAIL reset_data: got %h want 0000000", {ram_addr, ram_din, rsp0_rdata, rsp1_rdata});
    end
  endtask

  task automatic test_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_wr_en, ram_addr, ram_din, req0_ready, req1_ready, init_done} !== {1'b1, 4'(i), 8'h5A, 3'b000}) begin
        errs++;
        $display("FAIL clear_cycle%0d: got %h want %h", i, {ram_wr_en, ram_addr, ram_din, req0_ready, req1_ready, init_done},
                 {1'b1, 4'(i), 8'h5A, 3'b000});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({init_done, req0_ready, req1_ready, ram_wr_en, ram_addr} !== {4'b1100, 4'h7}) begin
      errs++;
      $display("FAIL first_grant: got %h want %h", {init_done, req0_ready, req1_ready, ram_wr_en, ram_addr}, {4'b1100, 4'h7});
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({req1_ready, ram_addr, rsp0_valid} !== {1'b1, 4'h8, 1'b0}) begin
      errs++;
      $display("FAIL second_grant: got %h want %h", {req1_ready, ram_addr, rsp0_valid}, {1'b1, 4'h8, 1'b0});
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 8'h5A}) begin
      errs++;
      $display("FAIL clear_rsp0: got %h want %h", {rsp0_valid, rsp1_valid, rsp0_rdata}, {2'b10, 8'h5A});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp1_rdata, rsp0_rdata} !== {2'b01, 8'h5A, 8'h5A}) begin
      errs++;
      $display("FAIL clear_rsp1: got %h want %h", {rsp0_valid, rsp1_valid, rsp1_rdata, rsp0_rdata}, {2'b01, 8'h5A, 8'h5A});
    end
    m_last = 1'b1;
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 7; k++) begin
      tick();
      idle_reqs();
      if (k < 4) begin
        req0_valid = 1'b1;
        req0_we    = (k < 2);
        req0_addr  = (k % 2 == 0) ? 4'h1 : 4'h2;
        req0_wdata = (k == 0) ? 8'hAA : 8'h55;
      end
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if ({req0_ready, ram_wr_en, ram_addr} !== {1'b1, (k < 2), req0_addr}) begin
          errs++;
          $display("FAIL wr_rd_accept%0d: got %h want %h", k, {req0_ready, ram_wr_en, ram_addr}, {1'b1, (k < 2), req0_addr});
        end
      end
      checks++;
      if (rsp0_valid !== (k == 4 || k == 5) ||
          (k >= 4 && rsp0_rdata !== ((k == 4) ? 8'hAA : 8'h55))) begin
        errs++;
        $display("FAIL wr_rd_rsp%0d: got v=%b d=%h want v=%b d=%h", k, rsp0_valid, rsp0_rdata,
                 (k == 4 || k == 5), (k == 4) ? 8'hAA : 8'h55);
      end
    end
    m_last = 1'b0;
  endtask

  task automatic test_contention();
    logic gs [6];
    logic lg;
    lg = m_last;
    for (int k = 0; k < 8; k++) begin
      tick();
      idle_reqs();
      if (k < 6) begin
        req0_valid = 1'b1; req0_addr = 4'h1;
        req1_valid = 1'b1; req1_addr = 4'h2;
      end
      @(negedge clk);
      if (k < 6) begin
        gs[k] = ~lg;
        lg = gs[k];
        checks++;
        if ({req0_ready, req1_ready} !== {~gs[k], gs[k]}) begin
          errs++;
          $display("FAIL contend_grant%0d: got %b want %b", k, {req0_ready, req1_ready}, {~gs[k], gs[k]});
        end
      end
      if (k >= 2) begin
        checks++;
        if ({rsp0_valid, rsp1_valid} !== {~gs[k-2], gs[k-2]} ||
            (gs[k-2] ? rsp1_rdata : rsp0_rdata) !== (gs[k-2] ? 8'h55 : 8'hAA)) begin
          errs++;
          $display("FAIL contend_rsp%0d: got v=%b d0=%h d1=%h want v=%b", k, {rsp0_valid, rsp1_valid},
                   rsp0_rdata, rsp1_rdata, {~gs[k-2], gs[k-2]});
        end
      end
    end
    m_last = lg;
  endtask

  task automatic test_hazard();
    for (int k = 0; k < 4; k++) begin
      tick();
      idle_reqs();
      if (k == 0) begin
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'hF; req1_wdata = 8'hC3;
      end else if (k == 1) begin
        req0_valid = 1'b1; req0_addr = 4'hF;
      end
      @(negedge clk);
      checks++;
      case (k)
        0: if ({req1_ready, ram_wr_en, ram_addr, ram_din} !== {2'b11, 4'hF, 8'hC3}) begin
             errs++;
             $display("FAIL hazard_wr: got %h want %h", {req1_ready, ram_wr_en, ram_addr, ram_din}, {2'b11, 4'hF, 8'hC3});
           end
        1: if ({req0_ready, ram_wr_en, ram_addr} !== {2'b10, 4'hF}) begin
             errs++;
             $display("FAIL hazard_rd: got %h want %h", {req0_ready, ram_wr_en, ram_addr}, {2'b10, 4'hF});
           end
        2: if (rsp0_valid !== 1'b0) begin
             errs++;
             $display("FAIL hazard_early: got %b want 0", rsp0_valid);
           end
        default: if ({rsp0_valid, rsp0_rdata} !== {1'b1, 8'hC3}) begin
             errs++;
             $display("FAIL hazard_rsp: got %h want %h", {rsp0_valid, rsp0_rdata}, {1'b1, 8'hC3});
           end
      endcase
    end
    m_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    idle_reqs();
    req0_valid = 1'b1; req0_addr = 4'h3;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_accept: got %b want 1", req0_ready);
    end
    tick();
    idle_reqs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, ram_wr_en, ram_addr, ram_din, rsp0_rdata, rsp1_rdata} !== 34'h0) begin
      errs++;
      $display("FAIL rstmid_zero: got %h want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, ram_wr_en,
               ram_addr, ram_din, rsp0_rdata, rsp1_rdata});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
        errs++;
        $display("FAIL rstmid_norsp%0d: got %b want 00", i, {rsp0_valid, rsp1_valid});
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    checks++;
    if ({ram_wr_en, ram_addr} !== {1'b1, 4'h8}) begin
      errs++;
      $display("FAIL rstmid_cnt8: got %h want %h", {ram_wr_en, ram_addr}, {1'b1, 4'h8});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_wr_en, ram_addr, ram_din, init_done} !== 14'h0) begin
      errs++;
      $display("FAIL rstmid_init_zero: got %h want 0", {ram_wr_en, ram_addr, ram_din, init_done});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_wr_en, ram_addr, ram_din, init_done} !== {1'b1, 4'(i), 8'h5A, 1'b0}) begin
        errs++;
        $display("FAIL reclear%0d: got %h want %h", i, {ram_wr_en, ram_addr, ram_din, init_done}, {1'b1, 4'(i), 8'h5A, 1'b0});
      end
      tick();
    end
    m_last = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) tick();
      idle_reqs();
      if (k < 16) begin
        if (k % 2 == 0) begin req0_valid = 1'b1; req0_addr = 4'(k); end
        else            begin req1_valid = 1'b1; req1_addr = 4'(k); end
      end
      @(negedge clk);
      if (k < 16) begin
        checks++;
        if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          errs++;
          $display("FAIL sweep_grant%0d: got %b", k, {req0_ready, req1_ready});
        end
      end
      if (k >= 2) begin
        checks++;
        if ({rsp0_valid, rsp1_valid} !== ((k % 2 == 0) ? 2'b10 : 2'b01) ||
            ((k % 2 == 0) ? rsp0_rdata : rsp1_rdata) !== 8'h5A) begin
          errs++;
          $display("FAIL sweep_rsp%0d: got v=%b d0=%h d1=%h want data 5a", k - 2, {rsp0_valid, rsp1_valid}, rsp0_rdata, rsp1_rdata);
        end
      end
    end
    m_last = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h5A;
    exp_rd0 = 8'h5A;
    exp_rd1 = 8'h5A;
    rq.delete();
  endtask

  task automatic test_random();
    logic       cv [2];
    logic       cwe [2];
    logic [3:0] ca [2];
    logic [7:0] cd [2];
    int         g;
    logic       ev0, ev1;
    rsp_t       r;
    cv[0] = 1'b0; cv[1] = 1'b0;
    for (int c = 0; c < 402; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (!cv[p]) begin
          cv[p]  = (c < 400) && ($urandom_range(0, 9) < 6);
          cwe[p] = 1'($urandom_range(0, 1));
          ca[p]  = 4'($urandom_range(0, 15));
          cd[p]  = 8'($urandom_range(0, 255));
        end
      end
      req0_valid = cv[0]; req0_we = cwe[0]; req0_addr = ca[0]; req0_wdata = cd[0];
      req1_valid = cv[1]; req1_we = cwe[1]; req1_addr = ca[1]; req1_wdata = cd[1];
      @(negedge clk);
      g = -1;
      if (cv[0] && cv[1]) g = m_last ? 0 : 1;
      else if (cv[0])     g = 0;
      else if (cv[1])     g = 1;
      checks++;
      if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
        errs++;
        $display("FAIL rand_grant c%0d: got %b want %b", c, {req0_ready, req1_ready}, {g == 0, g == 1});
      end
      if (g >= 0) begin
        checks++;
        if ({ram_wr_en, ram_addr} !== {cwe[g], ca[g]}) begin
          errs++;
          $display("FAIL rand_ram c%0d: got %h want %h", c, {ram_wr_en, ram_addr}, {cwe[g], ca[g]});
        end
        m_last = g[0];
        if (cwe[g]) ref_mem[ca[g]] = cd[g];
        else begin
          r.due = c + 2; r.port = g[0]; r.data = ref_mem[ca[g]];
          rq.push_back(r);
        end
        cv[g] = 1'b0;
      end
      ev0 = 1'b0; ev1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == c) begin
        r = rq.pop_front();
        if (r.port) begin ev1 = 1'b1; exp_rd1 = r.data; end
        else        begin ev0 = 1'b1; exp_rd0 = r.data; end
      end
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata} !== {ev0, ev1, exp_rd0, exp_rd1}) begin
        errs++;
        $display("FAIL rand_rsp c%0d: got %h want %h", c, {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata},
                 {ev0, ev1, exp_rd0, exp_rd1});
      end
    end
  endtask

  task automatic test_init_en0();
    @(negedge clk);
    checks++;
    if ({b_init_done, b_req0_ready, b_ram_wr_en, b_ram_addr, b_ram_din} !== {3'b100, 4'h0, 8'h00}) begin
      errs++;
      $display("FAIL en0_reset: got %h want %h", {b_init_done, b_req0_ready, b_ram_wr_en, b_ram_addr, b_ram_din}, {3'b100, 12'h0});
    end
    @(posedge clk);
    #1 rst_n_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_init_done, b_req0_ready, b_req1_ready, b_ram_wr_en, b_ram_addr} !== {4'b1100, 4'h3}) begin
      errs++;
      $display("FAIL en0_first: got %h want %h", {b_init_done, b_req0_ready, b_req1_ready, b_ram_wr_en, b_ram_addr}, {4'b1100, 4'h3});
    end
    checks++;
    if ({b_rsp0_valid, b_rsp1_valid, b_rsp0_rdata, b_rsp1_rdata} !== 18'h0) begin
      errs++;
      $display("FAIL en0_rsp: got %h want 0", {b_rsp0_valid, b_rsp1_valid, b_rsp0_rdata, b_rsp1_rdata});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_contention();
    test_hazard();
    test_reset_mid();
    test_random();
    test_init_en0();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ram_16x8_arbiter.md
# ram_16x8_arbiter

Two-port round-robin arbiter and sequencer for the 16x8 single-port RAM. After reset it clears all 16 locations to a programmable value, then shares the RAM between two requesters, one access per clock. Requesters use a valid/ready handshake. Read data returns on a fixed-latency response pulse. The block sits between the requesting logic and the RAM's clk / wr_en / addr / din / dout port.

## Interface
- INIT_VAL, 8'h00: value written to every RAM location during the post-reset clear.
- INIT_EN, 1: 1 runs the clear sequence after reset; 0 enters RUN directly.

Ports:
- clk  in  1  clock; RAM shares this clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester n has an access pending.
- req0_ready / req1_ready  out  1  access accepted this cycle.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  4  word address.
- req0_wdata / req1_wdata  in  8  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle read-data pulse.
- rsp0_rdata / rsp1_rdata  out  8  read data, valid while rspn_valid.
- init_done  out  1  high once the clear sequence completes.
- ram_wr_en  out  1  to RAM wr_en.
- ram_addr  out  4  to RAM addr.
- ram_din  out  8  to RAM din.
- ram_dout  in  8  from RAM dout.

## Operation
- **FSM states:**
  - INIT: 4-bit counter cnt steps 0..15. Drives ram_wr_en=1, ram_addr=cnt, ram_din=INIT_VAL. At cnt=15, moves to RUN and sets init_done=1 on the same edge. cnt wraps to 0.
  - RUN: arbitration, one access per cycle. Stays in RUN until reset.
- **Arbitration (RUN only, combinational):**
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester not named by the last_grant register.
  - last_grant updates to the granted index on every accepted transfer.
  - reqn_ready = RUN & grant==n. Both ready signals are 0 in INIT.
- **Transfer:** occurs when reqn_valid & reqn_ready.
  - Write: ram_wr_en=1, ram_addr=reqn_addr, ram_din=reqn_wdata.
  - Read: ram_wr_en=0, ram_addr=reqn_addr.
- **No transfer:** ram_wr_en=0; ram_addr and ram_din hold their previous values.
- **Requester rule:** a requester holds valid/we/addr/wdata stable while valid & !ready, and must not drop valid before acceptance.
- **RAM read timing:** the RAM has a registered read. ram_dout reflects the address presented in cycle N during cycle N+1.
- **Read response:** a two-stage tag pipeline (valid bit + requester id) tracks each read.
  - Stage 1 pairs with ram_dout in cycle N+1, which is captured at the end of N+1.
  - rspn_valid pulses for exactly cycle N+2, with rspn_rdata = captured ram_dout. Only the issuing port pulses.
- **No response backpressure:** the requester must consume the response in that cycle. rspn_rdata holds its value until the next response to port n.
- **Ordering:** accesses execute in grant order. A read granted in the cycle after a write to the same address returns the new data. Back-to-back reads sustain one per cycle.

## Timing
- **Reset (rst_n low, asynchronous):**
  - State is INIT if INIT_EN, else RUN.
  - cnt=0, last_grant=1 (port 0 wins the first tie), response pipeline cleared.
  - All ready and rsp outputs 0, rspn_rdata=8'h00, init_done=0 (1 if INIT_EN=0).
  - ram_wr_en=0, ram_addr=0, ram_din=0.
- **First cycles after release:** INIT occupies 16 cycles. The first request can be accepted in cycle 17 after reset release.
- **Reset mid-INIT:** the clear restarts from cnt=0.
- **Reset mid-read:** pending responses are discarded; no rsp pulse is produced.
- **Latency:** request acceptance to rsp pulse is 2 cycles.
- **Throughput:** 1 access per cycle aggregate. Under continuous contention each port gets every other cycle.
- **Write completion:** a write is complete at the edge ending its accept cycle. No response is generated.
- **Simultaneous events:** a write from one port and a pending read response for the other port in the same cycle are independent, and both proceed.

## Test plan
- Clear sequence: INIT_VAL=8'h5A, release reset. Expect init_done high after 16 cycles, then a port 0 read of addr 4'h7 returns 8'h5A on rsp0 two cycles after acceptance. Both ready signals stay 0 during INIT.
- Single-port write/read: port 0 writes 4'h1=8'hAA and 4'h2=8'h55 back-to-back, then reads 4'h1 and 4'h2. Expect rsp0_rdata 8'hAA then 8'h55 on consecutive cycles, each 2 cycles after its accept.
- Contention round-robin: both ports hold valid reads for 6 cycles (port 0 addr 4'h1, port 1 addr 4'h2). Expect grants 0,1,0,1,0,1, rsp0 and rsp1 alternating, and each port waiting exactly one cycle between grants.
- Write-then-read hazard: port 1 writes 4'hF=8'hC3, and port 0 reads 4'hF in the next cycle. Expect rsp0_rdata=8'hC3.
- Reset mid-operation: assert rst_n low during a read's wait cycle and again at cnt=8 of INIT. Expect no rsp pulse, immediate output zeroing, and a full 16-cycle clear after release with all locations reading INIT_VAL.
- INIT_EN=0: expect init_done=1 and ready asserted in the first cycle after reset release.
